core_top: RTL and testbench
===========================

CORE_TOP -- requirements
Module: core_top

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 No other ports; the bench observes state through these hierarchical names: pc, instr, rs1_data, rs2_data, rd, alu_result, reg_file.write_en, reg_file.registers[0:31], i_mem.mem[0:IMEM_WORDS-1].
REQ-006 i_mem.mem SHALL be a plain 32-bit array, loadable by $readmemh from word 0 at time zero.

Function
REQ-007 The core SHALL be a single-cycle RV32I implementation: one instruction fetched, executed and retired per clock, no pipeline, no stalls.
REQ-008 Fetch: instr = i_mem.mem[pc[log2(IMEM_WORDS)+1:2]], combinational; pc bits [1:0] ignored; address wraps modulo IMEM_WORDS.
REQ-009 Next PC: pc+4 by default; JAL pc+imm_J; JALR (rs1+imm_I) with bit 0 cleared; taken branch pc+imm_B.
REQ-010 Supported: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-011 LB/LH/LBU/LHU and SB/SH SHALL execute as full-word LW/SW (funct3 ignored).
REQ-012 FENCE, ECALL, EBREAK and any unrecognised opcode SHALL execute as NOP (no register/memory write, pc+4).
REQ-013 rs1_data/rs2_data: combinational register-file reads of instr[19:15]/instr[24:20]; register x0 always reads 0.
REQ-014 rd = instr[11:7]; alu_result = 32-bit ALU output (operand A rs1_data or pc, operand B rs2_data or immediate).
REQ-015 Arithmetic 32-bit modulo 2^32; shift amount = low 5 bits of operand B; SRA/SRAI arithmetic; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-016 Writeback value: ALU result for OP/OP-IMM/LUI/AUIPC, load data for loads, pc+4 for JAL/JALR.
REQ-017 reg_file.write_en SHALL be high combinationally for every instruction that writes rd; writes to x0 SHALL be discarded.
REQ-018 Data memory: word-addressed by alu_result bits [log2(DMEM_WORDS)+1:2], wraps; loads combinational; stores commit on rising edge.
REQ-019 Register and data-memory writes of an instruction take effect at the same edge that advances pc.

Reset
REQ-020 While reset is high at a rising edge, pc SHALL become 0 and no register or data-memory write SHALL occur.
REQ-021 All 32 registers SHALL be cleared to 0 on reset; data memory and i_mem contents SHALL NOT be altered by reset.
REQ-022 Reset asserted mid-program SHALL restart execution from pc 0 on the first edge after deassertion.

Structure
REQ-023 Opcode constants, funct3/funct7 encodings and the ALU-operation enum SHALL live in shared package core_pkg.
REQ-024 The register file SHALL be a sub-module reg_file (2 read, 1 write port, write_en, registers array), instantiated as reg_file.
REQ-025 Instruction memory SHALL be instantiated as i_mem with array mem; decode, ALU and data memory stay in core_top.

Verification
REQ-026 Loop summing 5+4+3+2+1 (x1 counter 5 to 0 via ADDI/BNE, x2 accumulator), 10 ns clock, reset for the first 7 ns -> x1=0, x2=15 by 500 ns.
REQ-027 Per-instruction program (every REQ-010 instruction, word load/store) writing 1 into x5..x29 on success -> all 25 registers equal 1 by 800 ns.
REQ-028 ADDI x0,x0,5 then ADD x3,x0,x0 -> x0 reads 0, x3=0.
REQ-029 SW x2,0(x0) with x2=0xDEADBEEF then LW x4,0(x0) -> x4=0xDEADBEEF; SRAI x5,x4,4 -> 0xFDEADBEE; SRLI -> 0x0DEADBEE.
REQ-030 JAL x1,+8 at pc 0x10 -> x1=0x14, pc=0x18; JALR x0,0(x1) -> pc=0x14.
REQ-031 Reset pulsed high for one edge mid-loop -> pc=0 and all registers 0 next cycle; program then re-runs to the same final values.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared RV32I opcode, funct3/funct7 encodings and ALU operation set
package core_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [6:0] F7_ALT  = 7'h20;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  // alt selects SUB/SRA; callers gate it so OP-IMM only honours it for shifts
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/core_imem.sv
// core_imem: word-wide instruction memory with combinational read
module core_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] mem [0:WORDS-1];
  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational reads, one synchronous write, x0 fixed at zero
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_write_en,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);
  logic        write_en;
  logic [31:0] registers [0:31];
  assign write_en   = i_write_en;
  assign o_rs1_data = (i_rs1 == 5'd0) ? 32'd0 : registers[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? 32'd0 : registers[i_rs2];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
    end else if (write_en && i_rd != 5'd0) begin
      registers[i_rd] <= i_wdata;
    end
  end
endmodule

// File: rtl/core_top.sv
// core_top: single-cycle RV32I core with decode, ALU and word-addressed data memory
module core_top
  import core_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  logic [31:0] pc, instr, rs1_data, rs2_data, alu_result;
  logic [4:0]  rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic [31:0] w_op_a, w_op_b, w_load_data, w_wdata, w_pc4, w_pc_next;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic        w_alt, w_a_pc, w_b_imm, w_we, w_store, w_branch, w_jal, w_jalr;
  logic        w_eq, w_lt, w_ltu, w_cond, w_taken;
  alu_op_e     w_alu_op;
  wb_sel_e     w_wb_sel;
  logic [31:0] r_dmem [0:DMEM_WORDS-1];
  // program image is preloaded at time zero, so the write port stays idle
  core_imem #(.WORDS(IMEM_WORDS)) i_mem (
    .clk    (clk),
    .i_we   (1'b0),
    .i_waddr({IAW{1'b0}}),
    .i_wdata(32'd0),
    .i_raddr(pc[IAW+1:2]),
    .o_rdata(instr)
  );
  reg_file reg_file (
    .clk       (clk),
    .reset     (reset),
    .i_rs1     (instr[19:15]),
    .i_rs2     (instr[24:20]),
    .i_rd      (rd),
    .i_write_en(w_we),
    .i_wdata   (w_wdata),
    .o_rs1_data(rs1_data),
    .o_rs2_data(rs2_data)
  );
  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_alt    = instr[31:25] == F7_ALT;
  assign rd       = instr[11:7];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'd0};
  assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    w_a_pc   = 1'b0;
    w_b_imm  = 1'b1;
    w_imm    = w_imm_i;
    w_alu_op = ALU_ADD;
    w_wb_sel = WB_ALU;
    w_we     = 1'b0;
    w_store  = 1'b0;
    w_branch = 1'b0;
    w_jal    = 1'b0;
    w_jalr   = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_imm    = w_imm_u;
        w_alu_op = ALU_PASSB;
        w_we     = 1'b1;
      end
      OP_AUIPC: begin
        w_a_pc = 1'b1;
        w_imm  = w_imm_u;
        w_we   = 1'b1;
      end
      OP_JAL: begin
        w_jal    = 1'b1;
        w_wb_sel = WB_PC4;
        w_we     = 1'b1;
      end
      OP_JALR: begin
        w_jalr   = 1'b1;
        w_wb_sel = WB_PC4;
        w_we     = 1'b1;
      end
      OP_BRANCH: w_branch = 1'b1;
      OP_LOAD: begin
        w_wb_sel = WB_MEM;
        w_we     = 1'b1;
      end
      OP_STORE: begin
        w_imm   = w_imm_s;
        w_store = 1'b1;
      end
      OP_IMM: begin
        w_alu_op = alu_decode(w_f3, w_alt && w_f3 == F3_SR);
        w_we     = 1'b1;
      end
      OP_REG: begin
        w_b_imm  = 1'b0;
        w_alu_op = alu_decode(w_f3, w_alt);
        w_we     = 1'b1;
      end
      default: ;
    endcase
  end
  assign w_op_a = w_a_pc ? pc : rs1_data;
  assign w_op_b = w_b_imm ? w_imm : rs2_data;
  always_comb begin
    case (w_alu_op)
      ALU_SUB:   alu_result = w_op_a - w_op_b;
      ALU_SLL:   alu_result = w_op_a << w_op_b[4:0];
      ALU_SLT:   alu_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU:  alu_result = {31'd0, w_op_a < w_op_b};
      ALU_XOR:   alu_result = w_op_a ^ w_op_b;
      ALU_SRL:   alu_result = w_op_a >> w_op_b[4:0];
      ALU_SRA:   alu_result = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
      ALU_OR:    alu_result = w_op_a | w_op_b;
      ALU_AND:   alu_result = w_op_a & w_op_b;
      ALU_PASSB: alu_result = w_op_b;
      default:   alu_result = w_op_a + w_op_b;
    endcase
  end
  assign w_eq   = rs1_data == rs2_data;
  assign w_lt   = $signed(rs1_data) < $signed(rs2_data);
  assign w_ltu  = rs1_data < rs2_data;
  assign w_cond = w_f3 == F3_BEQ  ? w_eq   :
                  w_f3 == F3_BNE  ? !w_eq  :
                  w_f3 == F3_BLT  ? w_lt   :
                  w_f3 == F3_BGE  ? !w_lt  :
                  w_f3 == F3_BLTU ? w_ltu  :
                  w_f3 == F3_BGEU ? !w_ltu : 1'b0;
  assign w_taken     = w_branch && w_cond;
  assign w_pc4       = pc + 32'd4;
  assign w_pc_next   = w_jal   ? pc + w_imm_j :
                       w_jalr  ? {alu_result[31:1], 1'b0} :
                       w_taken ? pc + w_imm_b : w_pc4;
  assign w_load_data = r_dmem[alu_result[DAW+1:2]];
  assign w_wdata     = w_wb_sel == WB_PC4 ? w_pc4 :
                       w_wb_sel == WB_MEM ? w_load_data : alu_result;
  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else pc <= w_pc_next;
  end
  // data memory has no reset: contents survive a core restart
  always_ff @(posedge clk) begin
    if (!reset && w_store) r_dmem[alu_result[DAW+1:2]] <= rs2_data;
  end
endmodule

// File: tb/tb_core_top.sv
// tb_core_top: table-driven, directed and randomized checks of the single-cycle RV32I core
module tb_core_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] prog [$];
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [$];
  localparam logic [31:0] NOP = 32'h00000013;
  logic [2:0] f3_op [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic       alt_op [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  core_top dut (.clk(clk), .reset(reset));
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic vec_t mk(logic [31:0] ins, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    return {ins, a, b, exp};
  endfunction

  // reference semantics of the RV32I register-register operations
  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return $unsigned($signed(a) >>> b[4:0]);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction
  function automatic logic ref_br(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic int regs_nonzero();
    int n = 0;
    for (int r = 0; r < 32; r++) if (dut.reg_file.registers[r] != 32'd0) n++;
    return n;
  endfunction
  task automatic fill_mem();
    for (int k = 0; k < 256; k++) dut.i_mem.mem[k] = (k < prog.size()) ? prog[k] : NOP;
  endtask
  task automatic load_prog();
    @(negedge clk);
    reset = 1'b1;
    fill_mem();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic li(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] t;
    t = v + 32'h800;
    prog.push_back(enc_u(7'h37, r, t[31:12]));
    prog.push_back(enc_i(7'h13, 3'd0, r, r, v[11:0]));
  endtask
  // x1=a, x2=b, then the instruction under test at pc 0x10; x4 is set only if 0x14 executes
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    prog.delete();
    li(5'd1, a);
    li(5'd2, b);
    prog.push_back(ins);
    prog.push_back(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd1));
    prog.push_back(enc_j(5'd0, 21'd0));
    load_prog();
    run(8);
  endtask
  task automatic loop_prog();
    prog.delete();
    prog.push_back(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
    prog.push_back(enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd0));
    prog.push_back(enc_r(7'h00, 3'd0, 5'd2, 5'd2, 5'd1));
    prog.push_back(enc_i(7'h13, 3'd0, 5'd1, 5'd1, 12'hfff));
    prog.push_back(enc_b(3'd1, 5'd1, 5'd0, 13'h1ff8));
    prog.push_back(enc_j(5'd0, 21'd0));
  endtask

  initial begin
    loop_prog();
    fill_mem();
    #7 reset = 1'b0;
    @(negedge clk);
    check("reset_pc", dut.pc, 32'd0);
    check("reset_regs_nonzero", regs_nonzero(), 0);
    run(30);
    check("loop_x1", dut.reg_file.registers[1], 32'd0);
    check("loop_x2", dut.reg_file.registers[2], 32'd15);

    loop_prog();
    load_prog();
    run(8);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midreset_pc", dut.pc, 32'd0);
    check("midreset_regs_nonzero", regs_nonzero(), 0);
    run(30);
    check("rerun_x1", dut.reg_file.registers[1], 32'd0);
    check("rerun_x2", dut.reg_file.registers[2], 32'd15);

    tbl.push_back(mk(enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 32'd12));
    tbl.push_back(mk(enc_r(7'h20, 3'd0, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 32'hfffffffe));
    tbl.push_back(mk(enc_r(7'h00, 3'd1, 5'd3, 5'd1, 5'd2), 32'd1, 32'd33, 32'd2));
    tbl.push_back(mk(enc_r(7'h00, 3'd2, 5'd3, 5'd1, 5'd2), 32'hffffffff, 32'd1, 32'd1));
    tbl.push_back(mk(enc_r(7'h00, 3'd3, 5'd3, 5'd1, 5'd2), 32'hffffffff, 32'd1, 32'd0));
    tbl.push_back(mk(enc_r(7'h00, 3'd4, 5'd3, 5'd1, 5'd2), 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0));
    tbl.push_back(mk(enc_r(7'h00, 3'd5, 5'd3, 5'd1, 5'd2), 32'h80000000, 32'd4, 32'h08000000));
    tbl.push_back(mk(enc_r(7'h20, 3'd5, 5'd3, 5'd1, 5'd2), 32'h80000000, 32'd4, 32'hf8000000));
    tbl.push_back(mk(enc_r(7'h00, 3'd6, 5'd3, 5'd1, 5'd2), 32'hf0f0f0f0, 32'h0f0f0000, 32'hfffff0f0));
    tbl.push_back(mk(enc_r(7'h00, 3'd7, 5'd3, 5'd1, 5'd2), 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000));
    tbl.push_back(mk(enc_i(7'h13, 3'd0, 5'd3, 5'd1, 12'h400), 32'd1, 32'd0, 32'h401));
    tbl.push_back(mk(enc_i(7'h13, 3'd3, 5'd3, 5'd1, 12'hfff), 32'd5, 32'd0, 32'd1));
    tbl.push_back(mk(enc_i(7'h13, 3'd5, 5'd3, 5'd1, 12'h41f), 32'h80000000, 32'd0, 32'hffffffff));
    tbl.push_back(mk(enc_u(7'h37, 5'd3, 20'h12345), 32'd0, 32'd0, 32'h12345000));
    tbl.push_back(mk(enc_u(7'h17, 5'd3, 20'h00001), 32'd0, 32'd0, 32'h00001010));
    tbl.push_back(mk(enc_i(7'h13, 3'd2, 5'd3, 5'd1, 12'hfff), 32'hfffffffe, 32'd0, 32'd1));
    tbl.push_back(mk(enc_i(7'h13, 3'd4, 5'd3, 5'd1, 12'hfff), 32'h0000ffff, 32'd0, 32'hffff0000));
    tbl.push_back(mk(enc_i(7'h13, 3'd7, 5'd3, 5'd1, 12'h0f0), 32'h12345678, 32'd0, 32'h00000070));
    tbl.push_back(mk(enc_i(7'h13, 3'd6, 5'd3, 5'd1, 12'h800), 32'd1, 32'd0, 32'hfffff801));
    tbl.push_back(mk(enc_i(7'h13, 3'd1, 5'd3, 5'd1, 12'd31), 32'd1, 32'd0, 32'h80000000));
    tbl.push_back(mk(enc_i(7'h67, 3'd0, 5'd3, 5'd1, 12'd9), 32'h10, 32'd0, 32'h14));
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].ins, tbl[i].a, tbl[i].b);
      check($sformatf("table%0d_x3", i), dut.reg_file.registers[3], tbl[i].exp);
    end

    prog.delete();
    prog.push_back(enc_u(7'h37, 5'd2, 20'hdeadc));
    prog.push_back(enc_i(7'h13, 3'd0, 5'd2, 5'd2, 12'heef));
    prog.push_back(enc_s(3'd2, 5'd0, 5'd2, 12'd0));
    prog.push_back(enc_i(7'h03, 3'd2, 5'd4, 5'd0, 12'd0));
    prog.push_back(enc_i(7'h13, 3'd5, 5'd5, 5'd4, 12'h404));
    prog.push_back(enc_i(7'h13, 3'd5, 5'd6, 5'd4, 12'd4));
    prog.push_back(enc_i(7'h03, 3'd0, 5'd7, 5'd0, 12'h400));
    prog.push_back(enc_s(3'd1, 5'd0, 5'd5, 12'h404));
    prog.push_back(enc_i(7'h03, 3'd2, 5'd8, 5'd0, 12'd4));
    prog.push_back(enc_j(5'd0, 21'd0));
    load_prog();
    run(14);
    check("lw_x4", dut.reg_file.registers[4], 32'hdeadbeef);
    check("srai_x5", dut.reg_file.registers[5], 32'hfdeadbee);
    check("srli_x6", dut.reg_file.registers[6], 32'h0deadbee);
    check("lb_wrap_x7", dut.reg_file.registers[7], 32'hdeadbeef);
    check("sh_wrap_lw_x8", dut.reg_file.registers[8], 32'hfdeadbee);

    prog.delete();
    prog.push_back(enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd9));
    prog.push_back(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd5));
    prog.push_back(enc_r(7'h00, 3'd0, 5'd3, 5'd0, 5'd0));
    prog.push_back(32'h00000073);
    prog.push_back(32'hffffffff);
    prog.push_back(32'h0ff0000f);
    prog.push_back(enc_j(5'd0, 21'd0));
    load_prog();
    run(1);
    check("addi_x3", dut.reg_file.registers[3], 32'd9);
    run(1);
    check("x0_stays_zero", dut.reg_file.registers[0], 32'd0);
    run(1);
    check("add_x0_x3", dut.reg_file.registers[3], 32'd0);
    run(1);
    check("ecall_pc", dut.pc, 32'd16);
    check("bad_op_write_en", {31'd0, dut.reg_file.write_en}, 32'd0);
    run(2);
    check("bad_op_x31", dut.reg_file.registers[31], 32'd0);
    check("fence_pc", dut.pc, 32'd24);

    prog.delete();
    repeat (4) prog.push_back(NOP);
    prog.push_back(enc_j(5'd1, 21'd8));
    prog.push_back(enc_j(5'd0, 21'd0));
    prog.push_back(enc_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0));
    load_prog();
    run(4);
    check("pre_jal_pc", dut.pc, 32'h10);
    run(1);
    check("jal_pc", dut.pc, 32'h18);
    check("jal_x1", dut.reg_file.registers[1], 32'h14);
    run(1);
    check("jalr_pc", dut.pc, 32'h14);
    run(3);
    check("spin_pc", dut.pc, 32'h14);

    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a, b, bm, ins;
      logic [11:0] imm;
      logic [4:0] sh;
      op = $urandom_range(0, 9);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op != 1 && $urandom_range(0, 1) == 1) begin
        imm = 12'($urandom);
        sh = 5'($urandom_range(0, 31));
        if (op == 2 || op == 6 || op == 7) imm = {alt_op[op] ? 7'h20 : 7'h00, sh};
        bm = {{20{imm[11]}}, imm};
        ins = enc_i(7'h13, f3_op[op], 5'd3, 5'd1, imm);
      end else begin
        bm = b;
        ins = enc_r(alt_op[op] ? 7'h20 : 7'h00, f3_op[op], 5'd3, 5'd1, 5'd2);
      end
      run_op(ins, a, b);
      check($sformatf("rand_alu%0d_op%0d", i, op), dut.reg_file.registers[3], ref_alu(op, a, bm));
    end

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [2:0] f3;
      int sel;
      a = $urandom;
      sel = $urandom_range(0, 2);
      b = (sel == 0) ? a : (sel == 1) ? a ^ 32'h80000000 : $urandom;
      f3 = br_f3[$urandom_range(0, 5)];
      run_op(enc_b(f3, 5'd1, 5'd2, 13'd8), a, b);
      check($sformatf("rand_br%0d_f3_%0d", i, f3), dut.reg_file.registers[4], ref_br(f3, a, b) ? 32'd0 : 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
